div: RTL and testbench

// - Signed 32-bit iterative divider (restoring, one quotient bit per cycle). Inverse companion of the Booth multiplier.
// - Sits beside the multiplier in the datapath and serves DIV. Driven by the control unit with init/stop, like mult.
// - Writes the MIPS HI/LO pair: lo = quotient, hi = remainder. Flags divide-by-zero.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 32 +++
 rtl/div.sv | 121 ++++++++++++
 tb/tb_div.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider.
package div_pkg;

  localparam int unsigned NBITS_DEF = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Unsigned magnitude of a two's-complement value; the most negative value maps to itself.
  function automatic logic [NBITS_DEF-1:0] mag32(input logic [NBITS_DEF-1:0] x);
    return x[NBITS_DEF-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the remainder left by one bit, pulling in
// the next dividend bit, and subtract the divisor when the result stays non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF
) (
  input  logic [NBITS:0]   r,
  input  logic [NBITS-1:0] q,
  input  logic [NBITS-1:0] mag_b,
  output logic [NBITS:0]   r_next,
  output logic [NBITS-1:0] q_next
);

  logic [NBITS+1:0] shifted;
  logic [NBITS+1:0] trial;

  // The shift is carried one bit wider than R so the sign of the trial
  // subtraction is unambiguous; R stays below mag_b so the result matches a 33-bit test.
  always_comb begin
    shifted = {r, q[NBITS-1]};
    trial   = shifted - {2'b00, mag_b};
    if (!trial[NBITS+1]) begin
      r_next = trial[NBITS:0];
      q_next = {q[NBITS-2:0], 1'b1};
    end else begin
      r_next = shifted[NBITS:0];
      q_next = {q[NBITS-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div.sv
// Signed iterative divider: one quotient bit per cycle on magnitudes,
// sign applied at the end. lo = quotient, hi = remainder.
module div
  import div_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             init,
  input  logic             stop,
  output logic [NBITS-1:0] hi,
  output logic [NBITS-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [NBITS-1:0]   opa;
  logic [NBITS-1:0]   opb;
  logic [NBITS-1:0]   mag_b;
  logic [NBITS:0]     r;
  logic [NBITS-1:0]   q;
  logic               qneg;
  logic               rneg;
  logic [NBITS:0]     r_step;
  logic [NBITS-1:0]   q_step;
  logic [NBITS-1:0]   mag_a_load;
  logic [NBITS-1:0]   mag_b_load;

  div_step #(.NBITS(NBITS)) u_step (
    .r      (r),
    .q      (q),
    .mag_b  (mag_b),
    .r_next (r_step),
    .q_next (q_step)
  );

  // Operand magnitudes computed from the latched operands during LOAD.
  always_comb begin
    mag_a_load = opa[NBITS-1] ? (~opa + 1'b1) : opa;
    mag_b_load = opb[NBITS-1] ? (~opb + 1'b1) : opb;
  end

  // Next-state logic; stop and init override normal sequencing.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (init) state_next = S_LOAD;
      S_LOAD:  state_next = (opb == '0) ? S_DONE : S_RUN;
      S_RUN:   if (cnt == CNT_W'(1)) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (init) state_next = S_LOAD;
    if (stop) state_next = S_IDLE;
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = (state == S_LOAD) || (state == S_RUN) || (state == S_FIX);
    done = (state == S_DONE);
  end

  // State register and datapath; rst and stop both clear everything.
  always_ff @(posedge clk) begin
    if (rst || stop) begin
      state    <= S_IDLE;
      cnt      <= '0;
      opa      <= '0;
      opb      <= '0;
      mag_b    <= '0;
      r        <= '0;
      q        <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (init) begin
        opa      <= a;
        opb      <= b;
        div_zero <= 1'b0;
      end else begin
        case (state)
          S_LOAD: begin
            if (opb == '0) begin
              div_zero <= 1'b1;
            end else begin
              mag_b <= mag_b_load;
              q     <= mag_a_load;
              r     <= '0;
              qneg  <= opa[NBITS-1] ^ opb[NBITS-1];
              rneg  <= opa[NBITS-1];
              cnt   <= CNT_W'(NBITS);
            end
          end
          S_RUN: begin
            r   <= r_step;
            q   <= q_step;
            cnt <= cnt - 1'b1;
          end
          S_FIX: begin
            lo <= qneg ? (~q + 1'b1) : q;
            hi <= rneg ? (~r[NBITS-1:0] + 1'b1) : r[NBITS-1:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed vector table, multi-cycle corner
// sequences (restart, stop, reset mid-run) and random signed pairs.
module tb_div;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        init;
  logic        stop;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  div #(.NBITS(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .init     (init),
    .stop     (stop),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pulse init for one edge with the given operands.
  task automatic start(input logic [31:0] va, input logic [31:0] vb);
    a    = va;
    b    = vb;
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      tick();
      n++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic finish_check(input string name, input logic [31:0] exp_lo,
                              input logic [31:0] exp_hi, input logic exp_dz,
                              input int exp_lat);
    int n;
    bit got;
    wait_done(n, got);
    chk({name, " latency"}, got ? n : 999, exp_lat);
    if (got) begin
      chk({name, " busy@done"}, busy, 1'b0);
      chk({name, " lo"}, lo, exp_lo);
      chk({name, " hi"}, hi, exp_hi);
      chk({name, " div_zero"}, div_zero, exp_dz);
      tick();
      chk({name, " done pulse"}, done, 1'b0);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic exp_dz, input int exp_lat);
    start(va, vb);
    chk({name, " busy@load"}, busy, 1'b1);
    finish_check(name, exp_lo, exp_hi, exp_dz, exp_lat);
  endtask

  initial begin
    int          n;
    int          dcount;
    logic [31:0] ra;
    logic [31:0] rb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;

    vecs[0]  = '{32'd7,         32'd2,         32'd3,         32'd1,         1'b0, 34};
    vecs[1]  = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 34};
    vecs[2]  = '{32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0, 34};
    vecs[3]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 34};
    vecs[4]  = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 34};
    vecs[5]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0, 34};
    vecs[6]  = '{32'hFFFFFFF8,  32'd2,         32'hFFFFFFFC,  32'd0,         1'b0, 34};
    vecs[7]  = '{32'h7FFFFFFF,  32'h80000000,  32'd0,         32'h7FFFFFFF,  1'b0, 34};
    vecs[8]  = '{32'h80000000,  32'h80000000,  32'd1,         32'd0,         1'b0, 34};
    vecs[9]  = '{32'd7,         32'd2,         32'd3,         32'd1,         1'b0, 34};
    vecs[10] = '{32'd5,         32'd0,         32'd3,         32'd1,         1'b1, 1};
    vecs[11] = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 34};

    rst  = 1'b1;
    a    = '0;
    b    = '0;
    init = 1'b0;
    stop = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset div_zero", div_zero, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].exp_lo,
             vecs[i].exp_hi, vecs[i].exp_dz, vecs[i].exp_lat);
    end

    // Restart: a second init five edges in discards the first operation.
    start(32'd100, 32'd7);
    repeat (4) tick();
    start(32'd20, 32'd3);
    finish_check("restart", 32'd6, 32'd2, 1'b0, 34);

    // Abort at the tenth edge after init.
    start(32'd100, 32'd7);
    repeat (9) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop busy", busy, 1'b0);
    chk("stop hi", hi, 32'd0);
    chk("stop lo", lo, 32'd0);
    chk("stop done", done, 1'b0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcount++;
    end
    chk("stop no done", dcount, 0);

    // Reset in the middle of RUN.
    run_op("pre-rst", 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 34);
    start(32'd100, 32'd7);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst div_zero", div_zero, 1'b0);
    run_op("post-rst", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 34);

    // Random signed pairs against the simulator's own signed / and %.
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = $urandom_range(20, 0) - 32'd10;
      if (i % 8 == 1) ra = $urandom_range(1000, 0) - 32'd500;
      if (rb == 32'd0) rb = 32'd1;
      if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      sq = $signed(ra) / $signed(rb);
      sr = $signed(ra) % $signed(rb);
      start(ra, rb);
      finish_check($sformatf("rnd%0d", i), sq, sr, 1'b0, 34);
    end

    n = checks;
    $display("Result: errors=%0d of %0d checks", errors, n);
    $finish;
  end

endmodule
